// File: rtl/aes_stream_ctrl.sv
`timescale 1ns/1ps
// Byte-stream front end for an AES block core: assembles 16 input bytes into a
// plaintext block, launches the core, then streams the ciphertext back out bytewise.
module aes_stream_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] core_pt,
    output logic         core_load,
    input  logic [127:0] core_ct,
    input  logic         core_valid,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         err_timeout
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   k;
    logic [IDX_W-1:0]   j;
    logic [IDX_W-1:0]   j_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [127:0]       cap;
    logic               in_fire_c;
    logic               out_fire_c;
    logic               tmo_hit_c;

    // Handshake and status flags decode straight from the state.
    assign in_ready   = (state == COLLECT);
    assign out_valid  = (state == EMIT);
    assign out_last   = (state == EMIT) && (j == 4'd15);
    assign busy       = (state != COLLECT);

    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = out_valid && out_ready;
    assign j_nxt      = j + 4'd1;
    // The counter reaches TIMEOUT-1 on the edge where this fires.
    assign tmo_hit_c  = (cnt == CNT_W'(TIMEOUT - 2));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; core_valid wins over a coincident timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (in_fire_c && (k == 4'd15)) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (core_valid) begin
                    state_nxt = EMIT;
                end else if (tmo_hit_c) begin
                    state_nxt = COLLECT;
                end
            end
            EMIT:    if (out_fire_c && (j == 4'd15)) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Input assembly, core launch and timeout tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k           <= '0;
            core_pt     <= '0;
            core_load   <= 1'b0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            core_load   <= 1'b0;
            err_timeout <= 1'b0;
            if (in_fire_c) begin
                core_pt[{~k, 3'b000} +: 8] <= in_data;
                k                           <= k + 4'd1;
                core_load                   <= (k == 4'd15);
            end
            if (state == START) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
                if (!core_valid && tmo_hit_c) begin
                    err_timeout <= 1'b1;
                    k           <= '0;
                end
            end
        end
    end

    // Ciphertext capture and byte emission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= '0;
            j        <= '0;
            out_data <= '0;
        end else begin
            if ((state == WAIT) && core_valid) begin
                cap      <= core_ct;
                j        <= '0;
                out_data <= core_ct[127:120];
            end else if (out_fire_c) begin
                j <= j_nxt;
                if (j == 4'd15) begin
                    out_data <= '0;
                end else begin
                    out_data <= cap[{~j_nxt, 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
`timescale 1ns/1ps
// Directed bench: dut_a uses the default timeout, dut_b uses TIMEOUT=8.
module tb_aes_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic [127:0] core_ct;
    logic         core_valid_a;
    logic         core_valid_b;
    logic         out_ready;

    logic         in_ready_a, core_load_a, out_valid_a, out_last_a, busy_a, err_a;
    logic [127:0] core_pt_a;
    logic [7:0]   out_data_a;
    logic         in_ready_b, core_load_b, out_valid_b, out_last_b, busy_b, err_b;
    logic [127:0] core_pt_b;
    logic [7:0]   out_data_b;

    int n_checks = 0;
    int n_errors = 0;
    int loads_a  = 0;

    always #5 clk = ~clk;

    aes_stream_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .core_pt(core_pt_a), .core_load(core_load_a),
        .core_ct(core_ct), .core_valid(core_valid_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_last(out_last_a),
        .busy(busy_a), .err_timeout(err_a)
    );

    aes_stream_ctrl #(.TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .core_pt(core_pt_b), .core_load(core_load_b),
        .core_ct(core_ct), .core_valid(core_valid_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b),
        .busy(busy_b), .err_timeout(err_b)
    );

    always @(posedge clk) if (core_load_a) loads_a <= loads_a + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        core_valid_a = 1'b0;
        core_valid_b = 1'b0;
        #1;
        check("rst_core_pt", core_pt_a, '0);
        check("rst_ctrl", {core_load_a, out_valid_a, out_last_a, busy_a, err_a}, '0);
        check("rst_out_data", out_data_a, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready_a, 1'b1);
    endtask

    // Streams n bytes base, base+1, ... with in_valid held high; returns #1 after the last edge.
    task automatic send_bytes(input logic [7:0] base, input int n);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            in_data  = base + 8'(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Drains one block from dut_a with a repeating out_ready pattern, checking every cycle.
    task automatic drain_a(input logic [127:0] ct, input logic [3:0] pat);
        int idx = 0;
        int cyc = 0;
        while (idx < 16 && cyc < 200) begin
            out_ready = pat[3 - (cyc % 4)];
            @(negedge clk);
            check("emit_valid", out_valid_a, 1'b1);
            check("emit_data", out_data_a, ct[(15 - idx) * 8 +: 8]);
            check("emit_last", out_last_a, idx == 15);
            @(posedge clk);
            if (out_ready) idx++;
            cyc++;
            #1;
        end
        check("emit_count", 32'(idx), 32'd16);
        out_ready = 1'b1;
    endtask

    logic [127:0] pt_exp;
    logic [127:0] ct1;
    logic [127:0] ct2;
    int           load_base;

    initial begin
        rst_n        = 1'b1;
        in_data      = '0;
        in_valid     = 1'b0;
        core_ct      = '0;
        core_valid_a = 1'b0;
        core_valid_b = 1'b0;
        out_ready    = 1'b1;
        ct1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ct2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

        // Basic block: assembly, single load, 10-cycle core, full-rate output.
        do_reset();
        load_base = loads_a;
        send_bytes(8'h05, 16);
        @(negedge clk);
        check("load_pulse", core_load_a, 1'b1);
        check("pt_basic", core_pt_a, 128'h05060708_090A0B0C_0D0E0F10_11121314);
        check("start_flags", {in_ready_a, busy_a, out_valid_a}, 3'b010);
        @(negedge clk);
        check("load_single", core_load_a, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        core_ct      = ct1;
        core_valid_a = 1'b1;
        @(posedge clk);
        #1 core_valid_a = 1'b0;
        check("out_latency", out_valid_a, 1'b1);
        drain_a(ct1, 4'b1111);
        @(negedge clk);
        check("post_in_ready", in_ready_a, 1'b1);
        check("post_out_valid", out_valid_a, 1'b0);
        check("load_count1", 32'(loads_a - load_base), 32'd1);

        // Output backpressure with 1,0,0,1 ready pattern.
        do_reset();
        send_bytes(8'h20, 16);
        repeat (2) @(posedge clk);
        #1;
        core_ct      = ct2;
        core_valid_a = 1'b1;
        @(posedge clk);
        #1 core_valid_a = 1'b0;
        drain_a(ct2, 4'b1001);
        @(negedge clk);
        check("stall_done", out_valid_a, 1'b0);

        // Timeout on the TIMEOUT=8 instance: one err pulse 8 cycles after START.
        do_reset();
        send_bytes(8'h30, 16);
        check("b_start", core_load_b, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("tmo_err_c%0d", c), err_b, c == 8);
            check("tmo_no_out", out_valid_b, 1'b0);
        end
        check("tmo_collect", {in_ready_b, busy_b}, 2'b10);

        // Reset mid-block discards the partial input.
        do_reset();
        load_base = loads_a;
        send_bytes(8'h80, 7);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_pt", core_pt_a, '0);
        #1 rst_n = 1'b1;
        send_bytes(8'h40, 16);
        pt_exp = 128'h40414243_44454647_48494A4B_4C4D4E4F;
        check("midrst_pt_new", core_pt_a, pt_exp);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_loads", 32'(loads_a - load_base), 32'd1);

        // core_valid coincident with the timeout threshold wins.
        do_reset();
        send_bytes(8'h50, 16);
        repeat (7) @(posedge clk);
        #1;
        check("race_no_err_yet", err_b, 1'b0);
        core_ct      = ct1;
        core_valid_b = 1'b1;
        @(posedge clk);
        #1 core_valid_b = 1'b0;
        check("race_err", err_b, 1'b0);
        check("race_emit", out_valid_b, 1'b1);
        check("race_data", out_data_b, 8'h00);
        @(posedge clk);
        #1;
        check("race_err_late", err_b, 1'b0);
        check("race_data2", out_data_b, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 1024, max cycles to wait for core_valid after core_load; legal range 2..65535.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_data  input  8  plaintext byte from upstream.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block accepts a byte; a transfer occurs when in_valid && in_ready on a clk edge.
REQ-007 core_pt  output  128  assembled plaintext to aes_encrypt.
REQ-008 core_load  output  1  one-cycle start pulse to aes_encrypt.
REQ-009 core_ct  input  128  ciphertext from aes_encrypt.
REQ-010 core_valid  input  1  core_ct valid.
REQ-011 out_data  output  8  ciphertext byte to downstream.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready on a clk edge.
REQ-014 out_last  output  1  high with the 16th byte of each block.
REQ-015 busy  output  1  high in any state other than COLLECT.
REQ-016 err_timeout  output  1  one-cycle pulse on core timeout.

Function
REQ-017 FSM states SHALL be COLLECT, START, WAIT, and EMIT; reset state is COLLECT.
REQ-018 COLLECT: in_ready=1; each transfer stores its byte at core_pt[127-8k -: 8] for byte index k=0..15, so the first byte lands in bits [127:120]; k increments per transfer.
REQ-019 On the transfer with k=15, the FSM SHALL go to START on the next edge, and k SHALL wrap to 0.
REQ-020 START: core_load=1 for exactly one cycle, the timeout counter is cleared, and the FSM unconditionally goes to WAIT.
REQ-021 core_pt SHALL remain stable from START until the FSM re-enters COLLECT.
REQ-022 WAIT: core_valid sampled high SHALL capture core_ct into an internal 128-bit register and move to EMIT; core_valid during COLLECT, START, or EMIT SHALL be ignored.
REQ-023 WAIT: the counter increments each cycle; if it reaches TIMEOUT-1 with core_valid low, err_timeout=1 for one cycle, the FSM goes to COLLECT, and k=0, so the block is dropped.
REQ-024 If core_valid and the timeout occur in the same cycle, core_valid SHALL win: capture, no error.
REQ-025 EMIT: out_valid=1 and out_data=captured[127-8j -: 8] for j=0..15; j advances only on an out transfer.
REQ-026 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-027 out_last SHALL be high exactly when j=15; on that transfer the FSM goes to COLLECT and j=0.
REQ-028 in_ready SHALL be 0 in START, WAIT, and EMIT; out_valid SHALL be 0 outside EMIT.
REQ-029 Latency SHALL be: last input byte edge -> core_load high in the next cycle; core_valid edge -> out_valid high in the next cycle.
REQ-030 Back-to-back: the first byte of the next block is accepted in the cycle after the out_last transfer.
REQ-031 All outputs are registered except in_ready, out_valid, out_last, and busy, which are decoded directly from the state.

Reset
REQ-032 rst_n low SHALL immediately force: state=COLLECT, k=j=0, counter=0, core_pt=0, capture register=0, core_load=0, out_valid=0, out_data=0, out_last=0, err_timeout=0, busy=0, in_ready=1 after release.
REQ-033 Reset asserted mid-block in any state SHALL discard partial input and pending output; no core_load or output byte is produced for that block after release.

Verification
REQ-034 Bytes 0x05..0x14 streamed with in_valid held high -> core_pt=0x05060708_090A0B0C_0D0E0F10_11121314 and a single core_load pulse one cycle after the 16th byte.
REQ-035 Core model returns core_ct=0x00112233_44556677_8899AABB_CCDDEEFF 10 cycles after load, out_ready=1 -> out bytes 0x00,0x11,...,0xFF on 16 consecutive cycles, out_last only on 0xFF, then in_ready=1.
REQ-036 out_ready toggled 1,0,0,1 during EMIT -> no byte is lost or duplicated, and out_data holds during stalls.
REQ-037 TIMEOUT=8 with core_valid never asserted -> err_timeout pulses once 8 cycles after START, state returns to COLLECT, and no out_valid occurs.
REQ-038 rst_n pulsed low after 7 input bytes, then 16 new bytes sent -> core_pt holds only the new 16 bytes, and exactly one core_load occurs.
REQ-039 core_valid asserted in the same cycle as the timeout threshold -> capture occurs, err_timeout stays 0, and EMIT is entered.
